sprite_blitter: RTL and testbench

- Downstream consumer of the sprite-index counter in the sprite engine. Reacts to the counter's next-sprite pulse and reads the indexed entry (x, y, sprite id, enable) from the location buffer.
- Copies that sprite's pixels from sprite ROM into the frame buffer, skipping transparent and off-screen pixels.
- Pulses done, which drives the counter's nxt input, so the counter advances to the next sprite.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_blitter_if.sv | 26 ++
 rtl/blit_pixel_ctr.sv | 36 +++
 rtl/sprite_blitter.sv | 90 +++++++++
 tb/tb_sprite_blitter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, derived widths and FSM state type for the sprite blitter.
package sprite_pkg;
   localparam int SPRT_W  = 16;
   localparam int SPRT_H  = 16;
   localparam int FB_W    = 320;
   localparam int FB_H    = 240;
   localparam int ID_W    = 6;
   localparam int COLOR_W = 4;
   localparam logic [COLOR_W-1:0] TRANSP = '0;

   localparam int CRD_W   = 10;
   localparam int SCR_W   = CRD_W + 1;
   localparam int FB_AW   = 17;
   localparam int PX_W    = $clog2(SPRT_W);
   localparam int PY_W    = $clog2(SPRT_H);
   localparam int PIX_AW  = $clog2(SPRT_W * SPRT_H);
   localparam int ROM_AW  = ID_W + PIX_AW;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_FLUSH, S_DONE
   } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Location-buffer, sprite-ROM and frame-buffer signals of the blitter.
interface sprite_blitter_if;
   import sprite_pkg::*;

   logic                start;
   logic [CRD_W-1:0]    loc_x;
   logic [CRD_W-1:0]    loc_y;
   logic [ID_W-1:0]     loc_id;
   logic                loc_en;
   logic [ROM_AW-1:0]   rom_addr;
   logic [COLOR_W-1:0]  rom_data;
   logic                fb_we;
   logic [FB_AW-1:0]    fb_addr;
   logic [COLOR_W-1:0]  fb_wdata;
   logic                busy;
   logic                done;

   modport slave (
      input  start, loc_x, loc_y, loc_id, loc_en, rom_data,
      output rom_addr, fb_we, fb_addr, fb_wdata, busy, done
   );
   modport master (
      output start, loc_x, loc_y, loc_id, loc_en, rom_data,
      input  rom_addr, fb_we, fb_addr, fb_wdata, busy, done
   );
endinterface

// File: rtl/blit_pixel_ctr.sv
// Raster counter over the sprite: px runs fastest, py advances when px wraps.
module blit_pixel_ctr
   import sprite_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            i_clr,
   input  logic            i_en,
   output logic [PX_W-1:0] o_px,
   output logic [PY_W-1:0] o_py,
   output logic            o_last
);
   localparam logic [PX_W-1:0] PX_MAX = PX_W'(SPRT_W - 1);
   localparam logic [PY_W-1:0] PY_MAX = PY_W'(SPRT_H - 1);

   logic [PX_W-1:0] r_px;
   logic [PY_W-1:0] r_py;

   always_ff @(posedge clk) begin
      if (!resetn || i_clr) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_en) begin
         if (r_px == PX_MAX) begin
            r_px <= '0;
            r_py <= r_py + 1'b1;
         end else begin
            r_px <= r_px + 1'b1;
         end
      end
   end

   assign o_px   = r_px;
   assign o_py   = r_py;
   assign o_last = (r_px == PX_MAX) && (r_py == PY_MAX);
endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from ROM into the frame buffer per start pulse, with
// transparency and right/bottom clipping; one pixel per cycle.
module sprite_blitter
   import sprite_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   sprite_blitter_if.slave bus
);
   blit_state_t       r_state, w_next;
   logic [CRD_W-1:0]  r_x, r_y;
   logic [ID_W-1:0]   r_id;
   logic [SCR_W-1:0]  r_sx, r_sy;
   logic              r_vld;
   logic [PX_W-1:0]   w_px;
   logic [PY_W-1:0]   w_py;
   logic              w_last, w_clr, w_en, w_in_fb;

   blit_pixel_ctr u_ctr (
      .clk    (clk),
      .resetn (resetn),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .o_px   (w_px),
      .o_py   (w_py),
      .o_last (w_last)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_en   = 1'b0;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_FETCH;
         S_FETCH: w_next = S_LATCH;
         S_LATCH: begin
            w_clr  = 1'b1;
            w_next = bus.loc_en ? S_DRAW : S_DONE;
         end
         S_DRAW: begin
            w_en = 1'b1;
            if (w_last) w_next = S_FLUSH;
         end
         S_FLUSH: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_x  <= '0;
         r_y  <= '0;
         r_id <= '0;
      end else if (r_state == S_LATCH) begin
         r_x  <= bus.loc_x;
         r_y  <= bus.loc_y;
         r_id <= bus.loc_id;
      end
   end

   // Issue stage: screen coordinates travel alongside the ROM read so they
   // line up with rom_data in the following cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_vld <= 1'b0;
         r_sx  <= '0;
         r_sy  <= '0;
      end else begin
         r_vld <= (r_state == S_DRAW);
         if (r_state == S_DRAW) begin
            r_sx <= SCR_W'(r_x) + SCR_W'(w_px);
            r_sy <= SCR_W'(r_y) + SCR_W'(w_py);
         end
      end
   end

   assign w_in_fb      = (r_sx < SCR_W'(FB_W)) && (r_sy < SCR_W'(FB_H));
   assign bus.rom_addr = {r_id, w_py, w_px};
   assign bus.fb_we    = r_vld && (bus.rom_data != TRANSP) && w_in_fb;
   assign bus.fb_addr  = r_vld ? FB_AW'(FB_AW'(r_sy) * FB_AW'(FB_W) + FB_AW'(r_sx)) : '0;
   assign bus.fb_wdata = r_vld ? bus.rom_data : '0;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench: vector table, reset-abort sequence and random sprites
// checked against a per-pixel reference model of the blit.
module tb_sprite_blitter;
   import sprite_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   sprite_blitter_if bus();
   sprite_blitter dut (.clk(clk), .resetn(resetn), .bus(bus));

   logic [COLOR_W-1:0] rom [0:(1<<ROM_AW)-1];
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int addr; int data; int off; } wr_t;
   typedef struct { int x; int y; int id; int en; int nwr; int first; int last; } vec_t;

   wr_t got[$];
   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  done_cnt = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference: walk the sprite in raster order; pixel k is written k+3
   // cycles after the start edge when opaque and on-screen.
   task automatic build_exp(input int x, input int y, input int id, input int en);
      exp_q.delete();
      if (en == 0) return;
      for (int py = 0; py < SPRT_H; py++)
         for (int px = 0; px < SPRT_W; px++) begin
            int c, sx, sy;
            wr_t w;
            c  = int'(rom[id*SPRT_W*SPRT_H + py*SPRT_W + px]);
            sx = x + px;
            sy = y + py;
            if (c != 0 && sx < FB_W && sy < FB_H) begin
               w.addr = sy*FB_W + sx;
               w.data = c;
               w.off  = 3 + py*SPRT_W + px;
               exp_q.push_back(w);
            end
         end
   endtask

   task automatic run_sprite(input string tag, input int x, input int y,
                             input int id, input int en, input int spur);
      int e0, off, done_off, mism, bad_addr;
      wr_t w;
      got.delete();
      build_exp(x, y, id, en);
      @(negedge clk);
      bus.loc_x  = CRD_W'(x);
      bus.loc_y  = CRD_W'(y);
      bus.loc_id = ID_W'(id);
      bus.loc_en = en[0];
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      e0 = cyc;
      done_off = -1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         off = cyc - e0;
         bus.start = (spur != 0) && (off == spur);
         if (bus.fb_we) begin
            w.addr = int'(bus.fb_addr);
            w.data = int'(bus.fb_wdata);
            w.off  = off;
            got.push_back(w);
         end
         if (bus.done) begin
            done_off = off;
            done_cnt++;
            break;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " busy_after_done"}, int'(bus.busy), 0);
      chk({tag, " done_latency"}, done_off, en ? SPRT_W*SPRT_H + 3 : 2);
      chk({tag, " write_count"}, got.size(), exp_q.size());
      mism = 0;
      bad_addr = 0;
      foreach (got[i]) begin
         if (got[i].addr >= FB_W*FB_H) bad_addr++;
         if (i < exp_q.size() &&
             (got[i].addr != exp_q[i].addr || got[i].data != exp_q[i].data ||
              got[i].off != exp_q[i].off)) begin
            if (mism == 0)
               $display("FAIL %s pixel %0d: got addr=%0d data=%0d off=%0d, expected addr=%0d data=%0d off=%0d",
                        tag, i, got[i].addr, got[i].data, got[i].off,
                        exp_q[i].addr, exp_q[i].data, exp_q[i].off);
            mism++;
         end
      end
      chk({tag, " pixel_mismatches"}, mism, 0);
      chk({tag, " addr_out_of_fb"}, bad_addr, 0);
   endtask

   vec_t vecs[$];

   initial begin
      int nz, we_seen, done_seen, busy_seen;
      bus.start = 1'b0; bus.loc_x = '0; bus.loc_y = '0; bus.loc_id = '0; bus.loc_en = 1'b0;
      for (int id = 0; id < 64; id++)
         for (int p = 0; p < SPRT_W*SPRT_H; p++)
            case (id)
               3:       rom[id*256+p] = 4'd7;
               4:       rom[id*256+p] = (p % 2 == 1) ? 4'd9 : 4'd0;
               5:       rom[id*256+p] = COLOR_W'((p % 15) + 1);
               default: rom[id*256+p] = COLOR_W'($urandom_range(0, 15));
            endcase

      repeat (3) @(negedge clk);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset fb_we", int'(bus.fb_we), 0);
      chk("reset rom_addr", int'(bus.rom_addr), 0);
      chk("reset fb_addr", int'(bus.fb_addr), 0);
      chk("reset fb_wdata", int'(bus.fb_wdata), 0);
      resetn = 1'b1;

      vecs = '{
         '{10, 20, 3, 1, 256, 6410, 11225},
         '{0, 0, 4, 1, 128, 1, 4815},
         '{310, 232, 5, 1, 80, 74550, 76799},
         '{319, 239, 5, 1, 1, 76799, 76799},
         '{304, 224, 5, 1, 256, 71984, 76799},
         '{305, 0, 5, 1, 240, 305, 5119},
         '{10, 20, 3, 0, 0, 0, 0},
         '{320, 0, 5, 1, 0, 0, 0}
      };
      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_sprite(tag, vecs[i].x, vecs[i].y, vecs[i].id, vecs[i].en, 0);
         chk({tag, " table_count"}, got.size(), vecs[i].nwr);
         if (vecs[i].nwr > 0 && got.size() > 0) begin
            chk({tag, " first_addr"}, got[0].addr, vecs[i].first);
            chk({tag, " last_addr"}, got[got.size()-1].addr, vecs[i].last);
         end
         if (vecs[i].id == 4) begin
            nz = 0;
            foreach (got[j]) if (got[j].data == 0) nz++;
            chk({tag, " transparent_written"}, nz, 0);
         end
      end

      // Reset asserted while pixel px=5 is being issued.
      @(negedge clk);
      bus.loc_x = 10'd10; bus.loc_y = 10'd20; bus.loc_id = 6'd3; bus.loc_en = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midreset busy", int'(bus.busy), 0);
      chk("midreset fb_we", int'(bus.fb_we), 0);
      resetn = 1'b1;
      we_seen = 0; done_seen = 0; busy_seen = 0;
      repeat (300) begin
         @(negedge clk);
         we_seen   += int'(bus.fb_we);
         done_seen += int'(bus.done);
         busy_seen += int'(bus.busy);
      end
      chk("midreset writes", we_seen, 0);
      chk("midreset done", done_seen, 0);
      chk("midreset busy_later", busy_seen, 0);
      run_sprite("after_reset", 10, 20, 3, 1, 0);

      // Back-to-back random sprites with a stray start pulse while busy.
      done_cnt = 0;
      for (int n = 0; n < 50; n++) begin
         int x, y, id, en, spur;
         x  = $urandom_range(0, 335);
         y  = $urandom_range(0, 255);
         id = $urandom_range(0, 63);
         en = ($urandom_range(0, 7) != 0) ? 1 : 0;
         spur = $urandom_range(1, en ? SPRT_W*SPRT_H + 3 : 2);
         run_sprite($sformatf("rnd%0d", n), x, y, id, en, spur);
      end
      chk("random done_pulses", done_cnt, 50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
